// File: rtl/e_hilo_md_pkg.sv
// Shared definitions for the E-stage HI/LO multiply/divide unit.
package hilo_pkg;

  // HILO_op encodings; bit 3 set means the operation is ignored.
  localparam logic [3:0] MFHI  = 4'b0000;
  localparam logic [3:0] MFLO  = 4'b0001;
  localparam logic [3:0] MTHI  = 4'b0010;
  localparam logic [3:0] MTLO  = 4'b0011;
  localparam logic [3:0] MULTU = 4'b0100;
  localparam logic [3:0] DIVU  = 4'b0101;
  localparam logic [3:0] MULT  = 4'b0110;
  localparam logic [3:0] DIV   = 4'b0111;

  // Default busy latencies for the multiplier and divider.
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_hilo_md_if.sv
// Handshake/data bundle between the E-stage controller and the HI/LO unit.
interface e_hilo_md_if;
  logic [3:0]  HILO_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;

  modport master (output HILO_op, start, A, B, input busy, HILO_out);
  modport slave  (input HILO_op, start, A, B, output busy, HILO_out);
endinterface

// File: rtl/e_hilo_md.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency mult/div,
// mthi/mtlo writes and the mfhi/mflo read path.
module e_hilo_md
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  e_hilo_md_if.slave   hilo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;   // only the signed/div selectors matter once started
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_nz;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  logic start_ok;
  logic mt_ok;

  assign hilo.busy     = (cnt != '0);
  assign hilo.HILO_out = (hilo.HILO_op == MFLO) ? lo : hi;

  assign start_ok = hilo.start && !hilo.HILO_op[3] && hilo.HILO_op[2];
  assign mt_ok    = !hilo.start && (hilo.HILO_op[3:1] == 3'b001);

  // Result arithmetic on the latched operands; the divisor is forced
  // nonzero so the dividers never see 0 (the commit is skipped anyway).
  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    b_nz   = (b_q == 32'd0) ? 32'd1 : b_q;
    a_s    = a_q;
    b_s    = b_nz;
    if ((a_q == 32'h8000_0000) && (b_nz == 32'hFFFF_FFFF)) begin
      // Most-negative / -1 overflows; wrap the quotient, remainder is 0.
      q_s = a_s;
      r_s = '0;
    end else begin
      q_s = a_s / b_s;
      r_s = a_s % b_s;
    end
    q_u = a_q / b_nz;
    r_u = a_q % b_nz;
  end

  // Operation start, latency countdown, result commit and mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        unique case (op_q)
          2'b00: {hi, lo} <= prod_u;
          2'b10: {hi, lo} <= prod_s;
          2'b01: begin
            if (b_q != 32'd0) begin
              lo <= q_u;
              hi <= r_u;
            end
          end
          default: begin
            if (b_q != 32'd0) begin
              lo <= q_s;
              hi <= r_s;
            end
          end
        endcase
      end
    end else if (start_ok) begin
      op_q <= hilo.HILO_op[1:0];
      a_q  <= hilo.A;
      b_q  <= hilo.B;
      cnt  <= hilo.HILO_op[0] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mt_ok) begin
      if (hilo.HILO_op[0]) lo <= hilo.A;
      else                 hi <= hilo.A;
    end
  end

endmodule

// File: tb/tb_e_hilo_md.sv
// Scoreboard bench for e_hilo_md: stimulus pushes expectations, a monitor
// on the falling edge pops and compares against busy or HILO_out.
module tb_e_hilo_md;
  import hilo_pkg::*;

  localparam logic [3:0] NOP = 4'b1000;

  typedef struct {
    string       name;
    logic [31:0] val;
    bit          is_busy;
  } chk_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_hilo_md_if bus();

  e_hilo_md #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hilo  (bus.slave)
  );

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  chk_t exp_q[$];
  logic [31:0] m_hi, m_lo;

  // Monitor: compare one expectation per flagged cycle.
  always @(negedge clk) begin : mon
    chk_t        e;
    logic [31:0] act;
    if (chk_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL no_expectation: monitor had nothing to compare");
      end else begin
        e   = exp_q.pop_front();
        act = e.is_busy ? {31'd0, bus.busy} : bus.HILO_out;
        if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit st, input bit chk, input bit isb, input string nm,
                      input logic [31:0] ev);
    chk_t c;
    bus.HILO_op = op;
    bus.start   = st;
    bus.A       = a;
    bus.B       = b;
    chk_en      = chk;
    if (chk) begin
      c.name = nm; c.val = ev; c.is_busy = isb;
      exp_q.push_back(c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string nm);
    tick(MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, {nm, "_hi"}, m_hi);
    tick(MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, {nm, "_lo"}, m_lo);
  endtask

  // Reference model: architectural results computed with plain arithmetic.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    case (op)
      MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        m_hi = ps[63:32]; m_lo = ps[31:0];
      end
      MULTU: begin
        pu = 64'(a) * 64'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end
      DIV: begin
        if (b != 0) begin
          sa = a; sb = b;
          if (a == 32'h8000_0000 && sb == -1) begin
            m_lo = a; m_hi = 0;
          end else begin
            m_lo = sa / sb; m_hi = sa % sb;
          end
        end
      end
      DIVU: begin
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ins_op, input logic [31:0] ins_a, input string nm);
    int n;
    n = op[0] ? 10 : 5;
    tick(op, a, b, 1'b1, 1'b1, 1'b1, {nm, "_busyT"}, 32'd0);
    for (int i = 1; i <= n; i++)
      tick(ins_op, ins_a, 32'd0, 1'b0, 1'b1, 1'b1, $sformatf("%s_busy%0d", nm, i), 32'd1);
    model_exec(op, a, b);
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, {nm, "_done"}, 32'd0);
    read_chk(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int          sel;

    m_hi = 0; m_lo = 0;
    reset = 1'b0;
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    reset = 1'b1;
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "reset_busy", 32'd0);
    read_chk("reset");

    run_md(MULT,  32'hFFFF_FFFE, 32'd3, NOP, 32'd0, "mult");
    run_md(MULTU, 32'hFFFF_FFFE, 32'd3, NOP, 32'd0, "multu");
    run_md(DIV,   32'hFFFF_FFF9, 32'd2, NOP, 32'd0, "div");
    run_md(DIVU,  32'd7,         32'd2, NOP, 32'd0, "divu");

    tick(MTHI, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0); m_hi = 32'h11;
    tick(MTLO, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0); m_lo = 32'h22;
    read_chk("preload");
    run_md(DIV, 32'd5, 32'd0, NOP, 32'd0, "div0");

    tick(MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0); m_hi = 32'h1234_5678;
    read_chk("mthi");
    run_md(MULTU, 32'd9, 32'd9, MTLO, 32'hABCD, "mtlo_busy");
    run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, MTHI, 32'h5555, "div_ovf");

    // Reset during the third busy cycle discards the in-flight multiply.
    tick(MTHI, 32'hDEAD, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    tick(MTLO, 32'hBEEF, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    tick(MULT, 32'd1000, 32'd1000, 1'b1, 1'b1, 1'b1, "rst_busyT", 32'd0);
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "rst_busy1", 32'd1);
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "rst_busy2", 32'd1);
    reset = 1'b0;
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "rst_busy3", 32'd1);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "rst_after", 32'd0);
    read_chk("rst_clear");
    for (int i = 0; i < 6; i++)
      tick(NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    read_chk("rst_nolate");

    // Randomized mix of operations, including zero divisors and reserved ops.
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      case (sel)
        0: run_md(MULT,  ra, rb, NOP, 32'd0, $sformatf("r%0d_mult", it));
        1: run_md(MULTU, ra, rb, NOP, 32'd0, $sformatf("r%0d_multu", it));
        2: run_md(DIV,   ra, rb, NOP, 32'd0, $sformatf("r%0d_div", it));
        3: run_md(DIVU,  ra, rb, NOP, 32'd0, $sformatf("r%0d_divu", it));
        4: begin
          tick(MTHI, ra, rb, 1'b0, 1'b0, 1'b0, "", 32'd0); m_hi = ra;
          read_chk($sformatf("r%0d_mthi", it));
        end
        5: begin
          tick(MTLO, ra, rb, 1'b0, 1'b0, 1'b0, "", 32'd0); m_lo = ra;
          read_chk($sformatf("r%0d_mtlo", it));
        end
        6: begin
          tick(4'b1110, ra, rb, 1'b1, 1'b0, 1'b0, "", 32'd0);
          tick(NOP, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, $sformatf("r%0d_rsvd_busy", it), 32'd0);
          read_chk($sformatf("r%0d_rsvd", it));
        end
        default: run_md(DIVU, ra, rb, MTHI, $urandom(), $sformatf("r%0d_divu_mt", it));
      endcase
    end

    tick(NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "", 32'd0);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/e_hilo_md.md
# e_hilo_md

Execute-stage multiply/divide unit holding the HI/LO registers of the pipelined MIPS core. It sits directly downstream of the E-stage controller and consumes its `HILO_op` and `start` decode. It latches operands, runs a fixed-latency mult/multu/div/divu, and asserts `busy` so D-stage hazard logic can stall HI/LO instructions. It also services mthi/mtlo writes and provides the mfhi/mflo read value for the E-stage result mux.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `HILO_op`  in  4  E-stage HI/LO operation code. Encodings: mfhi 0000, mflo 0001, mthi 0010, mtlo 0011, multu 0100, divu 0101, mult 0110, div 0111. Bit 3 is reserved.
- `start`  in  1  one-cycle pulse while a mult/multu/div/divu is in E.
- `A`  in  32  forwarded rs value (dividend / multiplicand / mthi/mtlo data).
- `B`  in  32  forwarded rt value (divisor / multiplier).
- `busy`  out  1  operation in progress.
- `HILO_out`  out  32  read value for mfhi/mflo.

## Operation
- State: `hi`, `lo` (32b each); `cnt` (4b+, sized for max(MULT_CYCLES, DIV_CYCLES)); latched op, latched A, latched B.
- Operations are acted on only when `HILO_op[3]`=0. Bit 3 set means no action.
- Start condition: `start`=1, `HILO_op[2]`=1, `busy`=0.
  - At the edge, latch A, B and op.
  - Load `cnt` with MULT_CYCLES (op[0]=0) or DIV_CYCLES (op[0]=1).
- `start` while `busy`=1 is ignored. D-stage stalling guarantees it never occurs.
- `busy` = (`cnt` != 0), driven combinationally from `cnt`. `cnt` decrements each cycle while nonzero.
- At the edge where `cnt`==1, commit the result:
  - mult: signed 64b {hi,lo} = A×B.
  - multu: unsigned 64b {hi,lo} = A×B.
  - div: lo = signed quotient, truncated toward zero; hi = remainder, sign of dividend.
  - divu: unsigned quotient into lo, unsigned remainder into hi.
  - Divisor 0: hi and lo are left unchanged. Busy duration is unchanged.
- mthi (0010) / mtlo (0011) with `busy`=0 and `start`=0: write A into hi/lo at the edge. While `busy`=1 the write is ignored.
- Read path, combinational: `HILO_out` = lo when `HILO_op`==0001, otherwise hi. During `busy` it returns the old value; the stall prevents it being consumed.
- Reset (`reset`=0 at an edge): hi=lo=0, `cnt`=0, latched operands=0. Any in-flight result is discarded. `busy`=0 and `HILO_out`=0 from the next cycle.

## Timing
- `start` in cycle T → `busy`=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo are updated at the end of T+N. mfhi/mflo sees the new value from T+N+1.
- `busy`=0 in cycle T itself. Hazard logic stalls on (`start` | `busy`).
- mthi/mtlo latency is one edge. The next cycle's mfhi/mflo returns the written value.
- Back-to-back: a new `start` is accepted in T+N+1.
- Result commit and a simultaneous mthi/mtlo cannot coincide (`busy`=1 blocks the write). Reset overrides everything.

## Structure
- Shared package `hilo_pkg`:
  - `HILO_op` encoding constants (MFHI, MFLO, MTHI, MTLO, MULTU, DIVU, MULT, DIV).
  - Default MULT_CYCLES / DIV_CYCLES.
- No sub-module. Arithmetic uses built-in `*`, `/`, `%` on the latched operands, computed at commit; the counter models the latency.

## Test plan
- Reset low for 2 cycles, then release → `busy`=0, mfhi and mflo both read 0x00000000.
- mult A=0xFFFFFFFE, B=3, start → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div A=0xFFFFFFF9, B=2 → 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1.
- Preload hi=0x11, lo=0x22; div A=5, B=0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- mthi A=0x12345678 → next cycle mfhi reads 0x12345678. mtlo A=0xABCD issued while busy → lo unchanged.
- Start mult, pull reset low in busy cycle 3 → next cycle `busy`=0, hi=lo=0, and no late commit occurs.
